// File: rtl/l4_host_queue.sv
// l4_host_queue: host-side command and result FIFOs between the PCI target logic and the L4 control FSM.
// Both FIFOs are register arrays with wrapping pointers and a registered occupancy count.
module l4_host_queue #(
    parameter int ABITS  = 4,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_wr,
    input  logic [DWIDTH-1:0] host_wdata,
    output logic              host_cmd_full,
    input  logic              host_rd,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              host_rd_valid,
    output logic              host_res_empty,
    input  logic              flush,
    input  logic              err_clr,
    output logic [ABITS:0]    cmd_count,
    output logic [ABITS:0]    res_count,
    output logic [3:0]        err_flags,
    output logic              cmd_empty,
    output logic [DWIDTH-1:0] cmd_in,
    input  logic              cmd_rd,
    output logic              result_full,
    input  logic [DWIDTH-1:0] result_out,
    input  logic              result_wr
);

    localparam int DEPTH = 1 << ABITS;
    localparam logic [ABITS:0] FULL_CNT = {1'b1, {ABITS{1'b0}}};

    logic [DWIDTH-1:0] cmd_mem [DEPTH];
    logic [ABITS-1:0]  cmd_wrptr;
    logic [ABITS-1:0]  cmd_rdptr;
    logic [ABITS:0]    cmd_cnt;
    logic              cmd_push;
    logic              cmd_pop;

    logic [DWIDTH-1:0] res_mem [DEPTH];
    logic [ABITS-1:0]  res_wrptr;
    logic [ABITS-1:0]  res_rdptr;
    logic [ABITS:0]    res_cnt;
    logic              res_push;
    logic              res_pop;

    logic [3:0]        new_err;

    // Flags come from the registered counts; strobes are qualified against them and a flush kills all of them.
    assign cmd_empty      = (cmd_cnt == '0);
    assign host_cmd_full  = (cmd_cnt == FULL_CNT);
    assign host_res_empty = (res_cnt == '0);
    assign result_full    = (res_cnt == FULL_CNT);
    assign cmd_count      = cmd_cnt;
    assign res_count      = res_cnt;

    assign cmd_push = host_wr   & ~host_cmd_full  & ~flush;
    assign cmd_pop  = cmd_rd    & ~cmd_empty      & ~flush;
    assign res_push = result_wr & ~result_full    & ~flush;
    assign res_pop  = host_rd   & ~host_res_empty & ~flush;

    assign cmd_in = cmd_empty ? '0 : cmd_mem[cmd_rdptr];

    assign new_err = flush ? 4'b0000 :
                     {result_wr & result_full, host_rd & host_res_empty,
                      host_wr & host_cmd_full, cmd_rd & cmd_empty};

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wrptr] <= host_wdata;
        end
        if (res_push) begin
            res_mem[res_wrptr] <= result_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cmd_wrptr <= '0;
            cmd_rdptr <= '0;
            cmd_cnt   <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wrptr <= cmd_wrptr + 1'b1;
            end
            if (cmd_pop) begin
                cmd_rdptr <= cmd_rdptr + 1'b1;
            end
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
                2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
                default: cmd_cnt <= cmd_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            res_wrptr <= '0;
            res_rdptr <= '0;
            res_cnt   <= '0;
        end else begin
            if (res_push) begin
                res_wrptr <= res_wrptr + 1'b1;
            end
            if (res_pop) begin
                res_rdptr <= res_rdptr + 1'b1;
            end
            case ({res_push, res_pop})
                2'b10:   res_cnt <= res_cnt + 1'b1;
                2'b01:   res_cnt <= res_cnt - 1'b1;
                default: res_cnt <= res_cnt;
            endcase
        end
    end

    // host_rdata is held across flushes; only an accepted pop replaces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            host_rdata    <= '0;
            host_rd_valid <= 1'b0;
        end else begin
            host_rd_valid <= res_pop;
            if (res_pop) begin
                host_rdata <= res_mem[res_rdptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_flags <= 4'b0000;
        end else begin
            err_flags <= (err_clr ? 4'b0000 : err_flags) | new_err;
        end
    end

endmodule

// File: tb/tb_l4_host_queue.sv
// Scoreboard bench for l4_host_queue: directed scenarios plus random traffic against queue-based models.
module tb_l4_host_queue;

    localparam int ABITS = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          host_wr = 1'b0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_cmd_full;
    logic          host_rd = 1'b0;
    logic [DW-1:0] host_rdata;
    logic          host_rd_valid;
    logic          host_res_empty;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic [ABITS:0] cmd_count;
    logic [ABITS:0] res_count;
    logic [3:0]    err_flags;
    logic          cmd_empty;
    logic [DW-1:0] cmd_in;
    logic          cmd_rd = 1'b0;
    logic          result_full;
    logic [DW-1:0] result_out = '0;
    logic          result_wr = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] cmd_model [$];
    logic [DW-1:0] res_model [$];
    logic [DW-1:0] exp_rd [$];
    logic [3:0]    err_model = 4'b0000;
    logic [DW-1:0] rdata_model = '0;

    l4_host_queue #(.ABITS(ABITS), .DWIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .host_wr(host_wr), .host_wdata(host_wdata), .host_cmd_full(host_cmd_full),
        .host_rd(host_rd), .host_rdata(host_rdata), .host_rd_valid(host_rd_valid),
        .host_res_empty(host_res_empty), .flush(flush), .err_clr(err_clr),
        .cmd_count(cmd_count), .res_count(res_count), .err_flags(err_flags),
        .cmd_empty(cmd_empty), .cmd_in(cmd_in), .cmd_rd(cmd_rd),
        .result_full(result_full), .result_out(result_out), .result_wr(result_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted host pop must produce exactly one valid pulse carrying the oldest word.
    always @(negedge clk) begin
        chk("host_rd_valid", {31'b0, host_rd_valid}, {31'b0, exp_rd.size() > 0});
        if (host_rd_valid === 1'b1 && exp_rd.size() > 0) begin
            chk("host_rdata", host_rdata, exp_rd.pop_front());
        end else if (exp_rd.size() > 0) begin
            void'(exp_rd.pop_front());
        end
    end

    task automatic idleInputs();
        host_wr = 1'b0; cmd_rd = 1'b0; result_wr = 1'b0; host_rd = 1'b0;
        flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cmd_model.delete();
        res_model.delete();
        exp_rd.delete();
        err_model = 4'b0000;
        rdata_model = '0;
    endtask

    // One clock of stimulus; the model decides acceptance from the occupancy before the edge.
    task automatic applyStimulus(input logic hw, input logic [DW-1:0] wd, input logic crd,
                                 input logic rwr, input logic [DW-1:0] rword, input logic hrd,
                                 input logic fl, input logic ec);
        bit cf, ce, rf, re;
        logic [3:0] new_err;
        host_wr = hw; host_wdata = wd; cmd_rd = crd;
        result_wr = rwr; result_out = rword; host_rd = hrd;
        flush = fl; err_clr = ec;
        cf = (cmd_model.size() == DEPTH);
        ce = (cmd_model.size() == 0);
        rf = (res_model.size() == DEPTH);
        re = (res_model.size() == 0);
        new_err = 4'b0000;
        @(posedge clk);
        #1;
        if (fl) begin
            cmd_model.delete();
            res_model.delete();
        end else begin
            if (crd && !ce) void'(cmd_model.pop_front());
            if (hw && !cf) cmd_model.push_back(wd);
            if (hrd && !re) begin
                rdata_model = res_model.pop_front();
                exp_rd.push_back(rdata_model);
            end
            if (rwr && !rf) res_model.push_back(rword);
            new_err = {rwr && rf, hrd && re, hw && cf, crd && ce};
        end
        err_model = (ec ? 4'b0000 : err_model) | new_err;
        idleInputs();
    endtask

    task automatic checkOutput();
        chk("cmd_count", {27'b0, cmd_count}, cmd_model.size());
        chk("res_count", {27'b0, res_count}, res_model.size());
        chk("cmd_empty", {31'b0, cmd_empty}, {31'b0, cmd_model.size() == 0});
        chk("host_cmd_full", {31'b0, host_cmd_full}, {31'b0, cmd_model.size() == DEPTH});
        chk("host_res_empty", {31'b0, host_res_empty}, {31'b0, res_model.size() == 0});
        chk("result_full", {31'b0, result_full}, {31'b0, res_model.size() == DEPTH});
        chk("err_flags", {28'b0, err_flags}, {28'b0, err_model});
        chk("host_rdata_hold", host_rdata, rdata_model);
        if (cmd_model.size() > 0) chk("cmd_in", cmd_in, cmd_model[0]);
    endtask

    initial begin
        int sent;
        doReset();
        checkOutput();
        chk("reset_cmd_in", cmd_in, '0);
        chk("reset_rd_valid", {31'b0, host_rd_valid}, '0);

        // Three commands in, three out in order.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 32'hA000_0000 + i, 0, 0, '0, 0, 0, 0);
            checkOutput();
        end
        chk("cmd_head_first", cmd_in, 32'hA000_0001);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, '0, 1'b1, 0, '0, 0, 0, 0);
            checkOutput();
        end
        chk("cmd_drained_empty", {31'b0, cmd_empty}, 32'd1);

        // Fill to 16, overflow on the 17th.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'hB000_0000 + i, 0, 0, '0, 0, 0, 0);
        checkOutput();
        applyStimulus(1'b1, 32'hDEAD_0017, 0, 0, '0, 0, 0, 0);
        checkOutput();
        chk("cmd_ovf_flags", {28'b0, err_flags}, 32'h2);

        // Full: simultaneous push and pop pops only.
        applyStimulus(1'b1, 32'hDEAD_0018, 1'b1, 0, '0, 0, 0, 0);
        checkOutput();
        chk("full_pushpop_count", {27'b0, cmd_count}, 32'd15);
        for (int i = 0; i < 10; i++) applyStimulus(0, '0, 1'b1, 0, '0, 0, 0, 0);
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hC000_0000 + i, 1'b1, 0, '0, 0, 0, 1'b1);
            checkOutput();
        end
        chk("mid_pushpop_count", {27'b0, cmd_count}, 32'd5);
        while (cmd_model.size() > 0) begin
            applyStimulus(0, '0, 1'b1, 0, '0, 0, 0, 0);
            checkOutput();
        end

        // Single result round trip, then underflow.
        applyStimulus(0, '0, 0, 0, '0, 0, 0, 1'b1);
        applyStimulus(0, '0, 0, 1'b1, 32'h1234_5678, 0, 0, 0);
        checkOutput();
        applyStimulus(0, '0, 0, 0, '0, 1'b1, 0, 0);
        checkOutput();
        applyStimulus(0, '0, 0, 0, '0, 1'b1, 0, 0);
        checkOutput();
        chk("res_udf_flags", {28'b0, err_flags}, 32'h4);
        applyStimulus(0, '0, 0, 0, '0, 0, 0, 1'b1);

        // 40 words through the result FIFO across the pointer wrap.
        sent = 0;
        for (int it = 0; it < 1000 && (sent < 40 || res_model.size() > 0); it++) begin
            logic do_wr, do_rd;
            do_wr = (sent < 40) && (res_model.size() < DEPTH) &&
                    ($urandom_range(0, 2) != 0 || res_model.size() == 0);
            do_rd = (res_model.size() > 0) &&
                    (res_model.size() > 1 || do_wr || sent >= 40) && ($urandom_range(0, 1) == 1 || sent >= 40);
            applyStimulus(0, '0, 0, do_wr, 32'h5000_0000 + sent, do_rd, 0, 0);
            if (do_wr) sent++;
            checkOutput();
        end
        chk("res_wrap_sent", sent, 32'd40);
        chk("res_wrap_err", {28'b0, err_flags}, '0);

        // Flush with host_wr active, error flag preserved, then cleared.
        applyStimulus(0, '0, 1'b1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'hF000_0000 + i, 0, 0, '0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, '0, 0, 1'b1, 32'hE000_0000 + i, 0, 0, 0);
        checkOutput();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 0, 0, '0, 0, 1'b1, 0);
        checkOutput();
        chk("flush_err_kept", {28'b0, err_flags}, 32'h1);
        chk("flush_cmd_count", {27'b0, cmd_count}, '0);
        applyStimulus(0, '0, 0, 0, '0, 0, 0, 1'b1);
        checkOutput();
        chk("err_clr_flags", {28'b0, err_flags}, '0);

        // Random soak with occasional flush, err_clr and a mid-run reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                doReset();
                checkOutput();
            end
            applyStimulus($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0);
            checkOutput();
        end

        applyStimulus(0, '0, 0, 0, '0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_rd.size(), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
